// File: rtl/banc_reg_param.sv
// rtl/banc_reg_param.sv - parameterised 2R1W register bank with power-up clear sweep
//
// Purpose: DEPTH = 2**ADDR_W registers of DATA_W bits.
//   Two combinational read ports and one synchronous write port.
//   After reset, a CLEAR sweep zeroes every entry, one per cycle, before Ready rises.
//   With ZERO_REG=1, register 0 always reads as zero and ignores writes.
// Optional feature: define BANC_REG_BYPASS_EN to forward same-cycle write data to
//   a read port whose address matches WriteRegister.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   RegEn         in   write enable
//   RR1, RR2      in   read addresses [ADDR_W]
//   WriteRegister in   write address [ADDR_W]
//   WriteData     in   write data [DATA_W]
//   RD1, RD2      out  read data [DATA_W]; zero while Ready=0
//   Ready         out  registered; high once the clear sweep has finished
//   WrDrop        out  registered one-cycle pulse; a write arrived while Ready=0

module banc_reg_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegEn,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              Ready,
    output logic              WrDrop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_ready;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_zero;
    logic              w_wr_commit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Register 0 is hard-wired to zero only when ZERO_REG is set.
    assign w_wr_zero   = (ZERO_REG != 0) && (WriteRegister == '0);
    assign w_wr_commit = (r_state == ST_RUN) && RegEn && !w_wr_zero;

    // Storage has one write port, shared between the clear sweep and user writes.
    // Reset suppresses both, so a write on a reset edge is lost.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = WriteRegister;
        w_mem_data = WriteData;
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_idx;
                w_mem_data = '0;
            end else if (w_wr_commit) begin
                w_mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + ADDR_W'(1);
                    // Writes cannot be accepted while sweeping; flag them.
                    r_wr_drop <= RegEn;
                    // All-ones index means this edge clears entry DEPTH-1.
                    if (&r_clr_idx) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_wr_drop <= 1'b0;
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_idx <= '0;
                    r_ready   <= 1'b0;
                    r_wr_drop <= 1'b0;
                end
            endcase
        end
    end

`ifdef BANC_REG_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    // Forward only writes that will actually commit: register 0 never forwards.
    assign w_fwd1 = RegEn && !w_wr_zero && (RR1 == WriteRegister);
    assign w_fwd2 = RegEn && !w_wr_zero && (RR2 == WriteRegister);
`endif

    always_comb begin
        w_rd1 = '0;
        if (r_ready) begin
            if (!((ZERO_REG != 0) && (RR1 == '0))) begin
                w_rd1 = r_mem[RR1];
            end
`ifdef BANC_REG_BYPASS_EN
            if (w_fwd1) begin
                w_rd1 = WriteData;
            end
`endif
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (r_ready) begin
            if (!((ZERO_REG != 0) && (RR2 == '0))) begin
                w_rd2 = r_mem[RR2];
            end
`ifdef BANC_REG_BYPASS_EN
            if (w_fwd2) begin
                w_rd2 = WriteData;
            end
`endif
        end
    end

    assign RD1    = w_rd1;
    assign RD2    = w_rd2;
    assign Ready  = r_ready;
    assign WrDrop = r_wr_drop;

endmodule

// File: tb/tb_banc_reg_param.sv
// tb/tb_banc_reg_param.sv - scoreboard bench for banc_reg_param against a behavioural model

module tb_banc_reg_param;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegEn;
    logic [ADDR_W-1:0] RR1;
    logic [ADDR_W-1:0] RR2;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              Ready;
    logic              WrDrop;

    always #5 clk = ~clk;

    banc_reg_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RegEn        (RegEn),
        .RR1          (RR1),
        .RR2          (RR2),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .RD1          (RD1),
        .RD2          (RD2),
        .Ready        (Ready),
        .WrDrop       (WrDrop)
    );

    typedef struct {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic              ready;
        logic              drop;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents array plus a count of clear cycles still owed.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_valid = 1'b0;
    int                m_sweep = 0;
    bit                m_ready = 1'b0;
    bit                m_drop  = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == 0);
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (!m_ready) return '0;
`ifdef BANC_REG_BYPASS_EN
        if (RegEn && (a == WriteRegister) && !is_zero_reg(a)) return WriteData;
`endif
        if (is_zero_reg(a)) return '0;
        return m_mem[a];
    endfunction

    // Advance the model by one clock edge using the inputs the bench is applying.
    task automatic model_step();
        if (reset) begin
            m_valid = 1'b1;
            m_sweep = DEPTH;
            m_ready = 1'b0;
            m_drop  = 1'b0;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (m_valid) begin
            if (m_sweep > 0) begin
                m_drop  = RegEn;
                m_sweep = m_sweep - 1;
                m_ready = (m_sweep == 0);
            end else begin
                m_drop = 1'b0;
                if (RegEn && !is_zero_reg(WriteRegister)) m_mem[WriteRegister] = WriteData;
            end
        end
    endtask

    task automatic drive(input bit r, input bit en, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] a1,
                         input logic [ADDR_W-1:0] a2);
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        reset         = r;
        RegEn         = en;
        WriteRegister = wa;
        WriteData     = wd;
        RR1           = a1;
        RR2           = a2;
        if (m_valid) begin
            e.rd1   = model_read(a1);
            e.rd2   = model_read(a2);
            e.ready = m_ready;
            e.drop  = m_drop;
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_cycle(input int p_en, input int p_rst);
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        wa = ADDR_W'($urandom);
        a1 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom);
        a2 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom);
        drive($urandom_range(0, 999) < p_rst, $urandom_range(0, 99) < p_en, wa,
              DATA_W'($urandom), a1, a2);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("RD1", RD1, mon_e.rd1);
            check("RD2", RD2, mon_e.rd2);
            check("Ready", DATA_W'(Ready), DATA_W'(mon_e.ready));
            check("WrDrop", DATA_W'(WrDrop), DATA_W'(mon_e.drop));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        RegEn         = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        RR1           = '0;
        RR2           = '0;

        // One reset edge, then the sweep; a write to reg 3 lands mid-sweep.
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, (i == 10), ADDR_W'(3), 32'hCAFE0003, ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
        end

        // Every address reads zero after the sweep, identically on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, '0, '0, ADDR_W'(i), ADDR_W'(i));
        end

        drive(1'b0, 1'b1, ADDR_W'(7), 32'hDEADBEEF, ADDR_W'(7), ADDR_W'(0));
        drive(1'b0, 1'b0, '0, '0, ADDR_W'(7), ADDR_W'(0));
        drive(1'b0, 1'b1, ADDR_W'(0), 32'h12345678, ADDR_W'(0), ADDR_W'(0));
        drive(1'b0, 1'b0, '0, '0, ADDR_W'(0), ADDR_W'(7));
        drive(1'b0, 1'b1, ADDR_W'(9), 32'hA5A5A5A5, ADDR_W'(9), ADDR_W'(9));
        drive(1'b0, 1'b0, '0, '0, ADDR_W'(9), ADDR_W'(3));

        // Reset in RUN, then again 20 cycles into the sweep.
        drive(1'b1, 1'b1, ADDR_W'(5), 32'h55555555, ADDR_W'(7), ADDR_W'(9));
        for (int i = 0; i < 20; i++) rand_cycle(30, 0);
        drive(1'b1, 1'b0, '0, '0, ADDR_W'(7), ADDR_W'(9));
        for (int i = 0; i < DEPTH + 8; i++) rand_cycle(30, 0);

        for (int i = 0; i < 400; i++) rand_cycle(60, 8);
        for (int i = 0; i < DEPTH + 4; i++) rand_cycle(50, 0);

        repeat (3) @(negedge clk);
        check("queue_drain", DATA_W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/banc_reg_param.md
BANC_REG_PARAM -- requirements
Module: banc_reg_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5: address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port RegEn  input  1  write enable.
REQ-007 SHALL have port RR1  input  ADDR_W  read address, port 1.
REQ-008 SHALL have port RR2  input  ADDR_W  read address, port 2.
REQ-009 SHALL have port WriteRegister  input  ADDR_W  write address.
REQ-010 SHALL have port WriteData  input  DATA_W  write data.
REQ-011 SHALL have port RD1  output  DATA_W  read data, port 1.
REQ-012 SHALL have port RD2  output  DATA_W  read data, port 2.
REQ-013 SHALL have port Ready  output  1  high when the bank accepts writes and reads are valid.
REQ-014 SHALL have port WrDrop  output  1  registered one-cycle pulse: a write was discarded.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR (sweep storage to zero) and RUN (normal operation).
REQ-016 In CLEAR, SHALL write zero to the entry at clear counter clr_idx on each edge, then increment clr_idx by 1.
REQ-017 SHALL transition CLEAR->RUN on the edge that clears entry DEPTH-1; the sweep takes exactly DEPTH cycles.
REQ-018 Ready SHALL be 1 only in RUN and SHALL be registered, not decoded from inputs.
REQ-019 While Ready=0, RD1/RD2 SHALL be 0, regardless of RR1/RR2.
REQ-020 In RUN, RDx SHALL combinationally return the entry addressed by RRx with zero-cycle latency.
REQ-021 In RUN, when RegEn=1, SHALL store WriteData at WriteRegister on the rising edge; the value is visible on reads from the next cycle.
REQ-022 With ZERO_REG=1, reads of address 0 SHALL return 0; writes to address 0 SHALL be discarded without asserting WrDrop.
REQ-023 WrDrop SHALL assert for exactly one cycle following any edge where RegEn=1 and Ready=0; the write is discarded.
REQ-024 Both read ports SHALL be independent; RR1 == RR2 returns identical data on both.
REQ-025 A write in the same cycle as a read of the same address SHALL follow REQ-035/REQ-036.

Reset
REQ-026 On any edge with reset=1, SHALL enter CLEAR, set clr_idx=0, Ready=0, WrDrop=0.
REQ-027 Reset SHALL take priority over RegEn; a write on a reset edge is discarded without WrDrop.
REQ-028 Reset asserted mid-CLEAR SHALL restart the sweep at clr_idx=0.
REQ-029 Reset asserted in RUN SHALL restart the full DEPTH-cycle sweep; prior contents are lost.
REQ-030 Reset values SHALL be RD1=0, RD2=0, Ready=0, WrDrop=0.
REQ-031 Storage contents SHALL be all-zero once Ready first rises; no file preload is used.

Configuration
REQ-032 Macro BANC_REG_BYPASS_EN SHALL select write-to-read forwarding.
REQ-033 Forwarding, when compiled in, SHALL apply only when Ready=1 and RegEn=1.
REQ-034 Forwarding SHALL be suppressed for address 0 when ZERO_REG=1.
REQ-035 With the macro defined, RRx == WriteRegister SHALL return WriteData on RDx in the same cycle.
REQ-036 With the macro undefined, RDx SHALL return the old stored value until after the write edge.

Verification
REQ-037 Reset 1 cycle, DEPTH=32 -> Ready=0 for 32 cycles, Ready=1 on cycle 33, RD1=RD2=0 for all addresses.
REQ-038 In RUN, write 0xDEADBEEF to reg 7 -> next cycle RR1=7 gives RD1=0xDEADBEEF; RR2=0 gives RD2=0.
REQ-039 In RUN, write 0x12345678 to reg 0 with ZERO_REG=1 -> RD1 at RR1=0 stays 0; WrDrop stays 0.
REQ-040 RegEn=1 to reg 3 during CLEAR cycle 10 -> WrDrop=1 for one cycle; after Ready, reg 3 reads 0.
REQ-041 Reset reasserted at CLEAR cycle 20 -> Ready rises 32 cycles after the final reset edge.
REQ-042 Same-cycle write 0xA5A5A5A5 to reg 9 with RR1=9 -> RD1=0xA5A5A5A5 with the macro defined; old value 0 with it undefined.
